// File: rtl/bf_io_uart.sv
// bf_io_uart: bfcpu I/O-bus slave bridging '.' writes and ',' reads to an 8N1 UART through TX/RX FIFOs
module bf_io_uart #(
    parameter logic [15:0] clks_per_bit = 16'd868,
    parameter int          fifo_aw      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_req,
    input  logic       io_dir,
    input  logic [7:0] io_wdata,
    output logic       io_ack,
    output logic [7:0] io_rdata,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       tx_full,
    output logic       rx_empty,
    output logic       rx_overrun
);
    typedef enum logic {B_IDLE, B_ACK} bus_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;

    localparam logic [15:0]      cpb_m1  = clks_per_bit - 16'd1;
    localparam logic [15:0]      half_m1 = (clks_per_bit >> 1) - 16'd1;
    localparam logic [fifo_aw:0] full_x  = {1'b1, {fifo_aw{1'b0}}};
    localparam logic [fifo_aw:0] one     = {{fifo_aw{1'b0}}, 1'b1};

    logic [7:0]       tx_mem [2**fifo_aw];
    logic [7:0]       rx_mem [2**fifo_aw];
    logic [fifo_aw:0] tx_wp, tx_rp, rx_wp, rx_rp;
    bus_t             bus_st, bus_nx;
    tx_t              tx_st, tx_nx;
    rx_t              rx_st, rx_nx;
    logic [15:0]      tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
    logic [2:0]       tx_idx, tx_idx_nx, rx_idx, rx_idx_nx;
    logic [7:0]       tx_sh, tx_sh_nx, rx_sh, rx_sh_nx;
    logic             rx_s1, rx_s2, rx_s3;
    logic             tx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop, rx_done;

    assign tx_full  = (tx_wp ^ tx_rp) == full_x;
    assign tx_empty = tx_wp == tx_rp;
    assign rx_full  = (rx_wp ^ rx_rp) == full_x;
    assign rx_empty = rx_wp == rx_rp;
    assign io_ack   = bus_st == B_ACK;
    assign uart_txd = tx_st == T_START ? 1'b0 : tx_st == T_DATA ? tx_sh[0] : 1'b1;
    assign tx_push  = bus_st == B_IDLE && io_req && io_dir && !tx_full;
    assign rx_pop   = bus_st == B_IDLE && io_req && !io_dir && !rx_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still takes the byte
    assign rx_push  = rx_done && (!rx_full || rx_pop);

    always_comb bus_nx = bus_st == B_IDLE ? ((tx_push || rx_pop) ? B_ACK : B_IDLE) : (io_req ? B_ACK : B_IDLE);

    always_comb begin
        tx_nx     = tx_st;
        tx_cnt_nx = tx_cnt - 16'd1;
        tx_idx_nx = tx_idx;
        tx_sh_nx  = tx_sh;
        tx_pop    = 1'b0;
        if (tx_st == T_IDLE || (tx_st == T_STOP && tx_cnt == 16'd0)) begin
            tx_pop    = !tx_empty;
            tx_nx     = tx_empty ? T_IDLE : T_START;
            tx_cnt_nx = cpb_m1;
            tx_sh_nx  = tx_mem[tx_rp[fifo_aw-1:0]];
        end else if (tx_cnt == 16'd0) begin
            tx_cnt_nx = cpb_m1;
            tx_idx_nx = tx_st == T_START ? 3'd0 : tx_idx + 3'd1;
            tx_sh_nx  = tx_st == T_START ? tx_sh : tx_sh >> 1;
            tx_nx     = tx_st == T_START ? T_DATA : (tx_idx == 3'd7 ? T_STOP : T_DATA);
        end
    end

    always_comb begin
        rx_nx     = rx_st;
        rx_cnt_nx = rx_cnt - 16'd1;
        rx_idx_nx = rx_idx;
        rx_sh_nx  = rx_sh;
        rx_done   = 1'b0;
        case (rx_st)
            R_IDLE: if (rx_s3 && !rx_s2) begin
                rx_nx     = R_START;
                rx_cnt_nx = half_m1;
            end
            R_START: if (rx_cnt == 16'd0) begin
                rx_nx     = rx_s2 ? R_IDLE : R_DATA;
                rx_cnt_nx = cpb_m1;
                rx_idx_nx = 3'd0;
            end
            R_DATA: if (rx_cnt == 16'd0) begin
                rx_sh_nx  = {rx_s2, rx_sh[7:1]};
                rx_idx_nx = rx_idx + 3'd1;
                rx_cnt_nx = cpb_m1;
                rx_nx     = rx_idx == 3'd7 ? R_STOP : R_DATA;
            end
            R_STOP: if (rx_cnt == 16'd0) begin
                rx_done = rx_s2;
                rx_nx   = rx_s2 ? R_IDLE : R_WAIT;
            end
            R_WAIT: rx_nx = rx_s2 ? R_IDLE : R_WAIT;
            default: rx_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[fifo_aw-1:0]] <= io_wdata;
        if (rx_push) rx_mem[rx_wp[fifo_aw-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_st     <= B_IDLE;
            tx_st      <= T_IDLE;
            rx_st      <= R_IDLE;
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_wp      <= '0;
            rx_rp      <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            tx_idx     <= '0;
            rx_idx     <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            io_rdata   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            bus_st     <= bus_nx;
            tx_st      <= tx_nx;
            rx_st      <= rx_nx;
            tx_wp      <= tx_push ? tx_wp + one : tx_wp;
            tx_rp      <= tx_pop ? tx_rp + one : tx_rp;
            rx_wp      <= rx_push ? rx_wp + one : rx_wp;
            rx_rp      <= rx_pop ? rx_rp + one : rx_rp;
            tx_cnt     <= tx_cnt_nx;
            rx_cnt     <= rx_cnt_nx;
            tx_idx     <= tx_idx_nx;
            rx_idx     <= rx_idx_nx;
            tx_sh      <= tx_sh_nx;
            rx_sh      <= rx_sh_nx;
            rx_s1      <= uart_rxd;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            io_rdata   <= rx_pop ? rx_mem[rx_rp[fifo_aw-1:0]] : io_rdata;
            rx_overrun <= rx_overrun | (rx_done & rx_full & !rx_pop);
        end
    end
endmodule
